sprite_layer: RTL and testbench
===============================

SPRITE_LAYER -- requirements
Module: sprite_layer

Parameters
REQ-001 SPR_W, default 64: sprite width in texels, power of two.
REQ-002 SPR_H, default 64: sprite height in texels, power of two.
REQ-003 FRAMES, default 4: animation frames stored back to back in ROM, 1..16.
REQ-004 SCALE_SHIFT, default 0: on-screen magnification is 2^SCALE_SHIFT, range 0..3.
REQ-005 ANIM_DIV, default 8: frame_tick pulses per automatic frame advance, range 1..255.
REQ-006 TRANSP, default 4'h0: palette index treated as transparent.
REQ-007 ADDR_W (derived) = clog2(FRAMES*SPR_W*SPR_H).

Interface
REQ-008 Ports, in order: name, direction, width, meaning.
- vga_clk, in, 1: the only clock; all state updates on its rising edge.
- reset_n, in, 1: asynchronous, active-low reset.
- DrawX, in, 10: current pixel x.
- DrawY, in, 10: current pixel y.
- blank, in, 1: 1 = active video.
- frame_tick, in, 1: one-cycle pulse, once per video frame.
- pos_x, in, 10: requested sprite top-left x.
- pos_y, in, 10: requested sprite top-left y.
- flip_h, in, 1: requested horizontal mirror.
- anim_en, in, 1: enables automatic frame advance.
- frame_load, in, 1: one-cycle request to jump to frame_sel.
- frame_sel, in, 4: target frame for frame_load.
- rom_addr, out, ADDR_W: registered address to the external synchronous ROM.
- rom_q, in, 4: ROM data, valid one vga_clk after rom_addr.
- pix_idx, out, 4: palette index for the pixel.
- pix_hit, out, 1: opaque sprite pixel in active video.
- cur_frame, out, 4: frame currently displayed.

Function
REQ-009 Shadow registers sx, sy, sflip SHALL load pos_x, pos_y, flip_h only in the cycle frame_tick=1. Between ticks, mid-frame input changes SHALL have no effect, so there is no tearing.
REQ-010 frame_load=1 SHALL set a pending flag and latch frame_sel. A later frame_load before the tick SHALL overwrite the latched value.
REQ-011 On frame_tick with pending=1, cur_frame SHALL take the latched value, or that value mod FRAMES if it is >= FRAMES. The tick counter SHALL clear and pending SHALL clear.
REQ-012 On frame_tick with pending=0 and anim_en=1:
- if tick counter = ANIM_DIV-1, the counter SHALL clear and cur_frame SHALL advance, wrapping FRAMES-1 -> 0;
- otherwise the counter SHALL increment.
REQ-013 With anim_en=0 and no pending load, cur_frame and the tick counter SHALL hold. A frame_load and frame_tick in the same cycle SHALL be taken as a load applied at that tick.
REQ-014 Stage 1 (edge N) SHALL compute the following, using 11-bit sums so no right/bottom overflow occurs:
- inside = DrawX >= sx, DrawX < sx + (SPR_W<<SCALE_SHIFT), DrawY >= sy, DrawY < sy + (SPR_H<<SCALE_SHIFT);
- lx = (DrawX-sx)>>SCALE_SHIFT and ly = (DrawY-sy)>>SCALE_SHIFT;
- if sflip=1, lx' = SPR_W-1-lx, else lx' = lx.
REQ-015 Stage 1 (edge N) SHALL register:
- rom_addr = cur_frame*SPR_W*SPR_H + ly*SPR_W + lx';
- hit1 = inside, and b1 = blank.
When inside=0, rom_addr SHALL be 0.
REQ-016 Edge N+1 SHALL register hit2 = hit1 and b2 = b1; rom_q becomes valid for this address at this edge.
REQ-017 Edge N+2 SHALL register:
- pix_idx = rom_q if hit2 & b2, else 0;
- pix_hit = hit2 & b2 & (rom_q != TRANSP).
Total latency from DrawX/DrawY sample to pix_hit/pix_idx SHALL be exactly 2 cycles, fully pipelined with one pixel per clock.
REQ-018 Sprites partially off-screen SHALL be clipped at right/bottom with no wrap to x=0 or y=0.

Reset
REQ-019 While reset_n=0, independent of vga_clk, the following SHALL be 0: rom_addr, pix_idx, pix_hit, cur_frame, tick counter, pending, sx, sy, sflip, hit1, hit2, b1, b2.
REQ-020 A reset asserted mid-line SHALL drop pix_hit immediately; after release, the first valid pixel SHALL appear 2 cycles after the first sample.

Verification
REQ-021 Scenario 1: sx=100, sy=50, SCALE_SHIFT=0, frame 0, DrawX=100, DrawY=50, blank=1 -> rom_addr=0 after 1 cycle; pix_hit=1 with pix_idx=rom_q after 2 cycles, for nonzero ROM data.
REQ-022 Scenario 2: flip_h=1, SCALE_SHIFT=1, DrawX=sx+2, DrawY=sy -> rom_addr=SPR_W-2; DrawX=sx+128 (just outside the 128-px width) -> pix_hit=0 and rom_addr=0.
REQ-023 Scenario 3: anim_en=1, ANIM_DIV=2, FRAMES=4, 8 frame_ticks -> cur_frame sequence 0,1,1,2,2,3,3,0.
REQ-024 Scenario 4: frame_load with frame_sel=2 mid-frame -> cur_frame unchanged until the next tick, then 2; frame_sel=6 with FRAMES=4 -> 2.
REQ-025 Scenario 5: pos_x changed mid-frame -> stage-1 hit tests use the old sx until the next frame_tick.
REQ-026 Scenario 6: rom_q=TRANSP inside the sprite -> pix_hit=0; blank=0 inside the sprite -> pix_hit=0 and pix_idx=0; reset pulse -> all outputs 0 at once.

Source files
------------

// File: rtl/sprite_layer.sv
// sprite_layer: single animated sprite overlay with a two-cycle pixel pipeline.
// Position and flip are double-buffered at frame_tick so a frame never tears.
// The stage-1 address goes to an external synchronous ROM, and its data is
// merged with the delayed hit/blank flags two edges after the pixel sample.
module sprite_layer #(
  parameter int          SPR_W       = 64,
  parameter int          SPR_H       = 64,
  parameter int          FRAMES      = 4,
  parameter int          SCALE_SHIFT = 0,
  parameter int          ANIM_DIV    = 8,
  parameter logic [3:0]  TRANSP      = 4'h0,
  parameter int          ADDR_W      = $clog2(FRAMES * SPR_W * SPR_H)
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              frame_tick,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic              flip_h,
  input  logic              anim_en,
  input  logic              frame_load,
  input  logic [3:0]        frame_sel,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_q,
  output logic [3:0]        pix_idx,
  output logic              pix_hit,
  output logic [3:0]        cur_frame
);

  localparam int LX_W     = $clog2(SPR_W);
  localparam int LY_W     = $clog2(SPR_H);
  localparam int FRAME_SZ = SPR_W * SPR_H;
  // On-screen extent, kept in 11 bits so sx + span never wraps past 1023.
  localparam logic [10:0] SPAN_X = 11'(SPR_W << SCALE_SHIFT);
  localparam logic [10:0] SPAN_Y = 11'(SPR_H << SCALE_SHIFT);

  // Shadow (frame-stable) copies of the position and mirror controls
  logic [9:0]        r_sx;
  logic [9:0]        r_sy;
  logic              r_sflip;

  // Animation state
  logic [3:0]        r_cur_frame;
  logic [7:0]        r_tick_cnt;
  logic              r_pending;
  logic [3:0]        r_sel;

  // Pipeline state
  logic [ADDR_W-1:0] r_rom_addr;
  logic              r_hit1;
  logic              r_b1;
  logic              r_hit2;
  logic              r_b2;
  logic [3:0]        r_pix_idx;
  logic              r_pix_hit;

  // Stage-1 combinational terms
  logic [10:0]       w_dx;
  logic [10:0]       w_dy;
  logic [10:0]       w_sx;
  logic [10:0]       w_sy;
  logic              w_inside;
  logic [LX_W-1:0]   w_lx;
  logic [LY_W-1:0]   w_ly;
  logic [LX_W-1:0]   w_lx_f;
  logic [ADDR_W-1:0] w_addr;

  // Frame-control combinational terms
  logic [3:0]        w_load_val;
  logic [3:0]        w_load_frame;
  logic [3:0]        w_next_frame;

  assign w_dx = {1'b0, DrawX};
  assign w_dy = {1'b0, DrawY};
  assign w_sx = {1'b0, r_sx};
  assign w_sy = {1'b0, r_sy};

  assign w_inside = (w_dx >= w_sx) && (w_dx < (w_sx + SPAN_X)) &&
                    (w_dy >= w_sy) && (w_dy < (w_sy + SPAN_Y));

  // Local texel coordinates; only meaningful when w_inside is set.
  assign w_lx = LX_W'((DrawX - r_sx) >> SCALE_SHIFT);
  assign w_ly = LY_W'((DrawY - r_sy) >> SCALE_SHIFT);

  // SPR_W is a power of two, so SPR_W-1-lx is just the bitwise complement.
  assign w_lx_f = r_sflip ? ~w_lx : w_lx;

  // Row-major texel index within a frame is {ly, lx} for power-of-two widths.
  assign w_addr = ADDR_W'(r_cur_frame * FRAME_SZ) + ADDR_W'({w_ly, w_lx_f});

  // A load arriving in the tick cycle itself takes precedence over the latch.
  assign w_load_val   = frame_load ? frame_sel : r_sel;
  assign w_load_frame = 4'(w_load_val % FRAMES);
  assign w_next_frame = (r_cur_frame == 4'(FRAMES - 1)) ? 4'd0 : r_cur_frame + 4'd1;

  // Capture position/flip only at the frame boundary
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sx    <= '0;
      r_sy    <= '0;
      r_sflip <= 1'b0;
    end else if (frame_tick) begin
      r_sx    <= pos_x;
      r_sy    <= pos_y;
      r_sflip <= flip_h;
    end
  end

  // Frame selection: pending jumps win over automatic advance at each tick
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cur_frame <= '0;
      r_tick_cnt  <= '0;
      r_pending   <= 1'b0;
      r_sel       <= '0;
    end else if (frame_tick) begin
      r_pending <= 1'b0;
      if (frame_load || r_pending) begin
        r_cur_frame <= w_load_frame;
        r_tick_cnt  <= '0;
      end else if (anim_en) begin
        if (r_tick_cnt == 8'(ANIM_DIV - 1)) begin
          r_tick_cnt  <= '0;
          r_cur_frame <= w_next_frame;
        end else begin
          r_tick_cnt <= r_tick_cnt + 8'd1;
        end
      end
    end else if (frame_load) begin
      r_pending <= 1'b1;
      r_sel     <= frame_sel;
    end
  end

  // Stage 1: hit test and ROM address; address parks at 0 outside the sprite
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rom_addr <= '0;
      r_hit1     <= 1'b0;
      r_b1       <= 1'b0;
    end else begin
      r_rom_addr <= w_inside ? w_addr : '0;
      r_hit1     <= w_inside;
      r_b1       <= blank;
    end
  end

  // Stage 2: delay flags to line up with the ROM's registered output
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hit2 <= 1'b0;
      r_b2   <= 1'b0;
    end else begin
      r_hit2 <= r_hit1;
      r_b2   <= r_b1;
    end
  end

  // Stage 3: merge texel with visibility and drop transparent texels
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pix_idx <= '0;
      r_pix_hit <= 1'b0;
    end else begin
      r_pix_idx <= (r_hit2 && r_b2) ? rom_q : 4'd0;
      r_pix_hit <= r_hit2 && r_b2 && (rom_q != TRANSP);
    end
  end

  assign rom_addr  = r_rom_addr;
  assign pix_idx   = r_pix_idx;
  assign pix_hit   = r_pix_hit;
  assign cur_frame = r_cur_frame;

endmodule

// File: tb/tb_sprite_layer.sv
// tb_sprite_layer: directed checks of sprite_layer on two instances sharing
// stimulus -- u0 at 1x scale, u1 at 2x scale, both with ANIM_DIV=2, 64x64, 4 frames.
// Each instance sees a registered ROM model holding (addr[3:0] + 1).
module tb_sprite_layer;

  logic        clk;
  logic        reset_n;
  logic [9:0]  draw_x;
  logic [9:0]  draw_y;
  logic        blank;
  logic        frame_tick;
  logic [9:0]  pos_x;
  logic [9:0]  pos_y;
  logic        flip_h;
  logic        anim_en;
  logic        frame_load;
  logic [3:0]  frame_sel;

  logic [13:0] addr0, addr1;
  logic [3:0]  q0, q1;
  logic [3:0]  idx0, idx1;
  logic        hit0, hit1;
  logic [3:0]  frm0, frm1;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_seq [8] = '{0, 1, 1, 2, 2, 3, 3, 0};

  sprite_layer #(.ANIM_DIV(2)) u0 (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(draw_x), .DrawY(draw_y),
    .blank(blank), .frame_tick(frame_tick), .pos_x(pos_x), .pos_y(pos_y),
    .flip_h(flip_h), .anim_en(anim_en), .frame_load(frame_load),
    .frame_sel(frame_sel), .rom_addr(addr0), .rom_q(q0), .pix_idx(idx0),
    .pix_hit(hit0), .cur_frame(frm0)
  );

  sprite_layer #(.ANIM_DIV(2), .SCALE_SHIFT(1)) u1 (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(draw_x), .DrawY(draw_y),
    .blank(blank), .frame_tick(frame_tick), .pos_x(pos_x), .pos_y(pos_y),
    .flip_h(flip_h), .anim_en(anim_en), .frame_load(frame_load),
    .frame_sel(frame_sel), .rom_addr(addr1), .rom_q(q1), .pix_idx(idx1),
    .pix_hit(hit1), .cur_frame(frm1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] rom_fn(input logic [13:0] a);
    return a[3:0] + 4'd1;
  endfunction

  // External synchronous ROM models
  always @(posedge clk) begin
    q0 <= rom_fn(addr0);
    q1 <= rom_fn(addr1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) begin
      $display("[TB] ok   %-14s observed %0d", tag, obs);
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic load(input logic [3:0] sel);
    frame_load = 1'b1;
    frame_sel  = sel;
    step();
    frame_load = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; draw_x = '0; draw_y = '0; blank = 1'b0; frame_tick = 1'b0;
    pos_x = '0; pos_y = '0; flip_h = 1'b0; anim_en = 1'b0;
    frame_load = 1'b0; frame_sel = '0;
    #1;
    check("rst_addr", addr0, 0);
    check("rst_hit", hit0, 0);
    check("rst_idx", idx0, 0);
    check("rst_frame", frm0, 0);
    steps(3);
    reset_n = 1'b1;
    step();

    // Load sprite position 100,50
    pos_x = 10'd100; pos_y = 10'd50;
    tick();

    // Scenario 1: top-left texel
    draw_x = 10'd100; draw_y = 10'd50; blank = 1'b1;
    step();
    check("s1_addr0", addr0, 0);
    check("s1_addr1", addr1, 0);
    steps(2);
    check("s1_hit0", hit0, 1);
    check("s1_idx0", idx0, 1);
    check("s1_hit1", hit1, 1);

    // Back-to-back pixels through the pipeline
    draw_x = 10'd105; step();
    check("pipe_addr0", addr0, 5);
    draw_x = 10'd106; step();
    step();
    check("pipe_idx_a", idx0, 6);
    step();
    check("pipe_idx_b", idx0, 7);

    // Second row and scaled row
    draw_x = 10'd100; draw_y = 10'd51; step();
    check("row1_addr0", addr0, 64);
    check("row1_addr1", addr1, 0);

    // Scenario 2: mirrored, 2x width boundary
    flip_h = 1'b1; tick();
    draw_x = 10'd102; draw_y = 10'd50; step();
    check("flip_addr0", addr0, 61);
    check("flip_addr1", addr1, 62);
    draw_x = 10'd228; step();
    check("edge2x_addr", addr1, 0);
    steps(2);
    check("edge2x_hit", hit1, 0);
    check("edge2x_idx", idx1, 0);

    // Right and bottom boundaries without mirroring
    flip_h = 1'b0; tick();
    draw_x = 10'd163; step();
    check("rlast_addr0", addr0, 63);
    check("rlast_addr1", addr1, 31);
    draw_x = 10'd164; step();
    check("rout_addr0", addr0, 0);
    check("rin_addr1", addr1, 32);
    steps(2);
    check("rout_hit0", hit0, 0);
    draw_x = 10'd99; steps(3);
    check("lout_hit0", hit0, 0);
    draw_x = 10'd100; draw_y = 10'd113; step();
    check("blast_addr0", addr0, 4032);
    draw_y = 10'd114; step();
    check("bout_addr0", addr0, 0);
    check("bin_addr1", addr1, 2048);

    // Right-edge clipping with no wrap to x=0
    pos_x = 10'd1000; tick();
    draw_x = 10'd1023; draw_y = 10'd50; step();
    check("clip_addr0", addr0, 23);
    draw_x = 10'd5; step();
    check("nowrap_addr0", addr0, 0);
    steps(2);
    check("nowrap_hit0", hit0, 0);

    // Scenario 5: mid-frame position change ignored until the tick
    pos_x = 10'd100; draw_x = 10'd100; steps(3);
    check("tear_hit0", hit0, 0);
    tick();
    steps(3);
    check("newpos_hit0", hit0, 1);

    // Scenario 6: transparent texel and blanking
    draw_x = 10'd115; steps(3);
    check("transp_hit0", hit0, 0);
    check("opaque_hit1", hit1, 1);
    check("opaque_idx1", idx1, 8);
    draw_x = 10'd100; blank = 1'b0; steps(3);
    check("blank_hit0", hit0, 0);
    check("blank_idx0", idx0, 0);
    blank = 1'b1;

    // Scenario 4: frame loads apply only at the tick, last one wins
    load(4'd1);
    load(4'd2);
    step();
    check("ld_hold", frm0, 0);
    tick();
    check("ld_apply", frm0, 2);
    step();
    check("ld_addr0", addr0, 8192);
    load(4'd3); tick();
    check("ld_3", frm0, 3);
    frame_load = 1'b1; frame_sel = 4'd6; tick(); frame_load = 1'b0;
    check("ld_mod", frm0, 2);
    check("ld_mod_u1", frm1, 2);
    tick();
    check("ld_cleared", frm0, 2);

    // Scenario 3: automatic advance every second tick
    load(4'd0); tick();
    anim_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      step();
      check($sformatf("anim_%0d", i), frm0, exp_seq[i]);
    end
    anim_en = 1'b0;
    tick(); tick();
    check("anim_hold", frm0, 0);

    // Mid-line reset clears everything at once
    load(4'd1); tick();
    steps(3);
    check("pre_rst_hit", hit0, 1);
    check("pre_rst_frame", frm0, 1);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    check("mrst_hit", hit0, 0);
    check("mrst_addr", addr0, 0);
    check("mrst_frame", frm0, 0);
    check("mrst_idx1", idx1, 0);
    steps(2);
    reset_n = 1'b1;
    tick();
    step();
    check("post_rst_addr", addr0, 0);
    step();
    check("post_rst_hit_a", hit0, 0);
    step();
    check("post_rst_hit_b", hit0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
